// File: rtl/fetch_redirect_arbiter_pkg.sv
// Shared definitions for the IF-stage fetch redirect arbiter: reset PC,
// FSM encodings and the redirect target priority mux.
package fetch_redirect_arbiter_pkg;

  localparam logic [31:0] STARTPOINT  = 32'hBFC0_0000;
  localparam int          SINGLE_WORD = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

  // Exception beats mispredict flush, which beats BSC diff correction.
  function automatic logic [SINGLE_WORD-1:0] redirect_target(
    input logic                   exc_valid,
    input logic [SINGLE_WORD-1:0] exc_pc,
    input logic                   flush_valid,
    input logic [SINGLE_WORD-1:0] flush_pc,
    input logic [SINGLE_WORD-1:0] diff_pc
  );
    if (exc_valid)        return exc_pc;
    else if (flush_valid) return flush_pc;
    else                  return diff_pc;
  endfunction

endpackage

// File: rtl/fetch_redirect_arbiter_tracker.sv
// In-flight I-Cache request tracker: counts accepted-but-unanswered requests
// and how many of them must be dropped after a redirect.
module fetch_inflight_tracker #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             resp_valid_i,
  input  logic             redirect_i,
  output logic             resp_keep_o,
  output logic             full_o,
  output logic [CNT_W-1:0] outst_o
);

  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum = {1'b0, outst_q} + {{CNT_W{1'b0}}, accept_i};
    if (resp_valid_i && sum != '0) sum = sum - (CNT_W+1)'(1);
    if (sum > (CNT_W+1)'(MAX_OUTST)) outst_d = CNT_W'(MAX_OUTST);
    else                             outst_d = sum[CNT_W-1:0];
  end

  // Everything still in flight after this cycle belongs to the old path.
  always_comb begin
    squash_d = squash_q;
    if (redirect_i)                         squash_d = outst_d;
    else if (resp_valid_i && squash_q != '0) squash_d = squash_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      outst_q  <= '0;
      squash_q <= '0;
    end else begin
      outst_q  <= outst_d;
      squash_q <= squash_d;
    end
  end

  assign resp_keep_o = resp_valid_i && (squash_q == '0);
  assign full_o      = (outst_q >= CNT_W'(MAX_OUTST));
  assign outst_o     = outst_q;

  resp_without_request: assert property (
    @(posedge clk) disable iff (!rst) resp_valid_i |-> (outst_q != '0 || accept_i)
  );

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// IF-stage fetch PC sequencer: picks the next fetch PC by redirect priority,
// drives the I-Cache index request and flags stale responses.
module fetch_redirect_arbiter
  import fetch_redirect_arbiter_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = STARTPOINT,
  parameter int          MAX_OUTST = 2,
  parameter int          CNT_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exc_valid_i,
  input  logic [SINGLE_WORD-1:0] exc_pc_i,
  input  logic                   flush_valid_i,
  input  logic [SINGLE_WORD-1:0] flush_pc_i,
  input  logic                   diff_valid_i,
  input  logic [SINGLE_WORD-1:0] diff_pc_i,
  input  logic [SINGLE_WORD-1:0] pred_pc_i,
  input  logic                   stop_fetch_i,
  output logic                   req_o,
  output logic [SINGLE_WORD-1:0] req_pc_o,
  input  logic                   req_ok_i,
  input  logic                   resp_valid_i,
  output logic                   resp_keep_o,
  output logic [CNT_W-1:0]       outst_o,
  output logic                   redirecting_o
);

  fetch_state_e           state_q, state_d;
  logic [SINGLE_WORD-1:0] pc_q, pc_d;
  logic                   redirect, accept, full, req, keep;

  assign redirect = exc_valid_i | flush_valid_i | diff_valid_i;
  assign accept   = req && req_ok_i;

  fetch_inflight_tracker #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .accept_i     (accept),
    .resp_valid_i (resp_valid_i),
    .redirect_i   (redirect),
    .resp_keep_o  (keep),
    .full_o       (full),
    .outst_o      (outst_o)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A redirect wins over a same-cycle accept; the accepted index is stale.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      state_d = REDIR;
      pc_d    = redirect_target(exc_valid_i, exc_pc_i, flush_valid_i, flush_pc_i, diff_pc_i);
    end else begin
      if (accept) pc_d = pred_pc_i;
      case (state_q)
        FETCH:   if (stop_fetch_i) state_d = HOLD;
        HOLD:    if (!stop_fetch_i) state_d = FETCH;
        REDIR:   if (accept) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // REDIR ignores stop_fetch: the instruction queue is being flushed anyway.
  always_comb begin
    req = 1'b0;
    case (state_q)
      FETCH:   req = !stop_fetch_i && !full;
      REDIR:   req = !full;
      default: req = 1'b0;
    endcase
    req = req && rst;
  end

  assign req_o         = req;
  assign req_pc_o      = pc_q;
  assign resp_keep_o   = keep && rst;
  assign redirecting_o = (state_q == REDIR);

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Directed bench for fetch_redirect_arbiter: free run, redirects, squash,
// HOLD and mid-stream reset, each check as an immediate assertion.
module tb_fetch_redirect_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, flush_valid, diff_valid;
  logic [31:0] exc_pc, flush_pc, diff_pc, pred_pc;
  logic        stop_fetch, req, req_ok, resp_valid, resp_keep, redirecting;
  logic [31:0] req_pc;
  logic [1:0]  outst;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  // Simple BTB: always predicts the next 16-byte block.
  assign pred_pc = req_pc + 32'd16;

  fetch_redirect_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .exc_valid_i   (exc_valid),
    .exc_pc_i      (exc_pc),
    .flush_valid_i (flush_valid),
    .flush_pc_i    (flush_pc),
    .diff_valid_i  (diff_valid),
    .diff_pc_i     (diff_pc),
    .pred_pc_i     (pred_pc),
    .stop_fetch_i  (stop_fetch),
    .req_o         (req),
    .req_pc_o      (req_pc),
    .req_ok_i      (req_ok),
    .resp_valid_i  (resp_valid),
    .resp_keep_o   (resp_keep),
    .outst_o       (outst),
    .redirecting_o (redirecting)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; exc_valid = 0; flush_valid = 0; diff_valid = 0;
    exc_pc = '0; flush_pc = '0; diff_pc = '0;
    stop_fetch = 0; req_ok = 1; resp_valid = 0;
    cyc(); cyc(); #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_pc", req_pc, 32'hBFC00000);
    chk("rst_outst", {30'd0, outst}, 32'd0);
    chk("rst_redir", {31'd0, redirecting}, 32'd0);
    chk("rst_keep", {31'd0, resp_keep}, 32'd0);

    // Free run, no responses: two accepts fill the window
    rst = 1'b1; #1;
    chk("run0_req", {31'd0, req}, 32'd1);
    chk("run0_pc", req_pc, 32'hBFC00000);
    cyc(); #1;
    chk("run1_pc", req_pc, 32'hBFC00010);
    chk("run1_req", {31'd0, req}, 32'd1);
    cyc(); #1;
    chk("run2_pc", req_pc, 32'hBFC00020);
    chk("run2_outst", {30'd0, outst}, 32'd2);
    chk("run2_req_full", {31'd0, req}, 32'd0);

    // Flush with two requests in flight
    flush_valid = 1; flush_pc = 32'h80001234; req_ok = 0;
    cyc(); flush_valid = 0; resp_valid = 1; #1;
    chk("fl_redir", {31'd0, redirecting}, 32'd1);
    chk("fl_pc", req_pc, 32'h80001234);
    chk("fl_resp1_keep", {31'd0, resp_keep}, 32'd0);
    cyc(); #1;
    chk("fl_resp2_keep", {31'd0, resp_keep}, 32'd0);
    chk("fl_req_redir", {31'd0, req}, 32'd1);
    cyc(); resp_valid = 0; req_ok = 1; #1;
    chk("fl_outst0", {30'd0, outst}, 32'd0);
    cyc(); req_ok = 0; resp_valid = 1; #1;
    chk("fl_resp3_keep", {31'd0, resp_keep}, 32'd1);
    chk("fl_back_fetch", {31'd0, redirecting}, 32'd0);
    chk("fl_pc_next", req_pc, 32'h80001244);

    // All three redirect sources at once: exception wins
    cyc(); resp_valid = 0;
    exc_valid = 1; exc_pc = 32'hBFC00380;
    flush_valid = 1; flush_pc = 32'h11111110;
    diff_valid = 1; diff_pc = 32'h22222220;
    cyc(); exc_valid = 0; flush_valid = 0; diff_valid = 0; #1;
    chk("prio_pc", req_pc, 32'hBFC00380);
    chk("prio_redir", {31'd0, redirecting}, 32'd1);

    // Redirect in the same cycle as an accept at outst=0
    req_ok = 1; diff_valid = 1; diff_pc = 32'h00001000;
    cyc(); diff_valid = 0; req_ok = 0; resp_valid = 1; #1;
    chk("racc_pc", req_pc, 32'h00001000);
    chk("racc_outst", {30'd0, outst}, 32'd1);
    chk("racc_keep", {31'd0, resp_keep}, 32'd0);
    cyc(); resp_valid = 0; req_ok = 1;
    cyc(); req_ok = 0; resp_valid = 1; #1;
    chk("racc_live_keep", {31'd0, resp_keep}, 32'd1);

    // stop_fetch holds the PC, a diff redirect breaks through
    cyc(); resp_valid = 0; stop_fetch = 1; req_ok = 1; #1;
    chk("stop0_req", {31'd0, req}, 32'd0);
    cyc(); #1;
    chk("stop1_req", {31'd0, req}, 32'd0);
    chk("stop1_pc", req_pc, 32'h00001010);
    cyc(); #1;
    chk("stop2_pc", req_pc, 32'h00001010);
    diff_valid = 1; diff_pc = 32'h00400020;
    cyc(); diff_valid = 0; #1;
    chk("hold_redir_req", {31'd0, req}, 32'd1);
    chk("hold_redir_pc", req_pc, 32'h00400020);
    cyc(); stop_fetch = 0; #1;
    chk("after_redir_pc", req_pc, 32'h00400030);
    cyc(); req_ok = 0; #1;
    chk("pre_rst_outst", {30'd0, outst}, 32'd2);

    // Redirect to load squash, then reset mid-stream
    flush_valid = 1; flush_pc = 32'h12340000;
    cyc(); flush_valid = 0; rst = 1'b0; #1;
    chk("pre_rst_redir", {31'd0, redirecting}, 32'd1);
    cyc(); #1;
    chk("mrst_outst", {30'd0, outst}, 32'd0);
    chk("mrst_pc", req_pc, 32'hBFC00000);
    chk("mrst_redir", {31'd0, redirecting}, 32'd0);
    rst = 1'b1; req_ok = 1; #1;
    chk("mrst_req", {31'd0, req}, 32'd1);
    cyc(); req_ok = 0; resp_valid = 1; #1;
    chk("mrst_squash_clear", {31'd0, resp_keep}, 32'd1);
    cyc(); resp_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_arbiter.md
Name: fetch_redirect_arbiter

Overview:
Sequences I-Cache index requests for the IF stage. Each cycle it picks the next fetch PC from four sources, by priority: CP0 exception, SBA mispredict flush, BSC diff correction, BTB sequential prediction. It tracks in-flight cache requests and marks stale responses for squash after a redirect. It sits between the PC register path and the I-Cache sram-like port.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC after reset.
MAX_OUTST, 2, maximum accepted-but-unanswered requests (1..3).
CNT_W, 2, width of outstanding/squash counters; must hold MAX_OUTST.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
exc_valid_i  in  1  CP0 exception redirect
exc_pc_i  in  32  exception target
flush_valid_i  in  1  SBA mispredict flush
flush_pc_i  in  32  corrected target
diff_valid_i  in  1  BSC/BTB disagreement
diff_pc_i  in  32  BSC target
pred_pc_i  in  32  BTB next PC for the current req_pc_o
stop_fetch_i  in  1  instruction queue full
req_o  out  1  cache index request
req_pc_o  out  32  fetch PC (unaligned; the aligner is downstream)
req_ok_i  in  1  cache accepted index this cycle
resp_valid_i  in  1  cache data_ok
resp_keep_o  out  1  response this cycle is live (0 = drop)
outst_o  out  CNT_W  outstanding request count
redirecting_o  out  1  redirect target latched, not yet accepted

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, outst=0, squash=0, req_o=0, resp_keep_o=0, redirecting_o=0.
- Redirect select: redir = exc|flush|diff. Target = exc ? exc_pc : flush ? flush_pc : diff_pc. A redirect overrides any same-cycle accept: pc <= target and state <= REDIR, even if req_ok_i=1 that cycle.
- States:
  - FETCH: req_o = !stop_fetch_i && outst<MAX_OUTST. If req_o&&req_ok_i, then pc <= pred_pc_i. If stop_fetch_i, go to HOLD.
  - HOLD: req_o=0 and pc is held. Return to FETCH when stop_fetch_i=0. A redirect goes to REDIR.
  - REDIR: req_o = outst<MAX_OUTST, with stop_fetch ignored because the queue is flushed by the redirector. On accept: pc <= pred_pc_i, state <= FETCH. A new redirect reloads pc and stays in REDIR.
- redirecting_o = (state==REDIR).
- req_pc_o = pc, combinational from the register. The index is valid in the same cycle as req_o.
- Outstanding counter: outst_next = outst + (req_o&&req_ok_i) − (resp_valid_i). It saturates at MAX_OUTST, and req_o is gated at full.
  - resp_valid_i with outst=0 is a protocol error; the counter is held at 0 (assert in sim).
- Squash counter on redirect: squash <= outst + (req_o&&req_ok_i) − (resp_valid_i). A request accepted in the redirect cycle is stale.
- Otherwise, squash decrements on each resp_valid_i while squash>0.
- resp_keep_o = resp_valid_i && squash==0. The same-cycle redirect does not affect the current response's keep; that ordering is left to the downstream epoch check.
- Back-to-back redirects: the later one wins and squash is recomputed from the current outst. The counter never underflows.
- Mid-operation reset (rst=0) clears all state in the next cycle. Responses after reset are ignored by the cache-side reset.
- Arithmetic: counters are CNT_W unsigned with no wrap. PC is a full 32-bit register.

Decomposition:
- Shared header MyDefines: STARTPOINT (RESET_PC), state encodings FETCH=2'd0, HOLD=2'd1, REDIR=2'd2, and SINGLE_WORD width.
- One natural sub-module: fetch_inflight_tracker. It owns outst/squash and produces resp_keep_o and the full flag. The FSM and PC mux stay in the top module.

Test Plan:
- Reset then free run, with pred_pc_i = pc+16 and req_ok_i=1 always. Required: req_pc_o = BFC00000, BFC00010, BFC00020 in successive cycles; outst rises to 2 and req_o drops while no responses arrive.
- With outst=2, assert flush_valid_i with flush_pc_i=80001234. Required: the next cycle shows redirecting_o=1 and req_pc_o=80001234. The following two resp_valid_i give resp_keep_o=0; the third gives resp_keep_o=1.
- Same cycle: exc_valid_i (exc_pc_i=BFC00380), flush_valid_i, diff_valid_i. Required: req_pc_o=BFC00380.
- Redirect coinciding with req_ok_i=1 and outst=0. Required: squash=1, and the first response is dropped.
- stop_fetch_i=1 for 3 cycles in FETCH. Required: req_o=0 and pc held. Raising diff_valid_i (diff_pc_i=00400020) during HOLD gives req_o=1 at 00400020 while stop_fetch_i is still 1.
- rst=0 mid-stream with outst=2. Required: next cycle outst=0, squash=0, req_pc_o=BFC00000, state FETCH.
